// File: rtl/imem_loader.sv
// Packs a host byte stream little-endian into 32-bit words and writes them to instruction memory,
// holding the CPU in reset until the load completes. Optional checksum: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0] csum,
`endif
  output logic [15:0] word_count
);

  localparam logic [15:0] DepthW = DEPTH[15:0];

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wc_q, wc_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic        start;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      buf_q   <= '0;
      addr_q  <= BASE_ADDR;
      wc_q    <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      last_q  <= last_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    addr_d    = addr_q;
    wc_d      = wc_q;
    err_d     = err_q;
    last_d    = last_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    cpu_reset = 1'b1;
    start     = 1'b0;

    unique case (state_q)
      StIdle: start = load_start;
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d  = idx_q + 2'd1;
          last_d = in_last;
          if (idx_q == 2'd3 || in_last) state_d = StWrite;
        end
      end
      StWrite: begin
        // Words past capacity are dropped but the stream keeps draining to in_last.
        if (wc_q < DepthW) begin
          imem_we = 1'b1;
          addr_d  = addr_q + 32'd4;
          wc_d    = wc_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + buf_q;
`endif
        end else begin
          err_d = 1'b1;
        end
        buf_d   = '0;
        idx_d   = '0;
        last_d  = 1'b0;
        state_d = last_q ? StDone : StLoad;
      end
      StDone: begin
        start     = load_start;
        done      = ~load_start;
        cpu_reset = load_start;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StLoad;
      idx_d   = '0;
      buf_d   = '0;
      addr_d  = BASE_ADDR;
      wc_d    = '0;
      err_d   = 1'b0;
      last_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = imem_we ? buf_q : 32'h0;
  assign err        = err_q;
  assign word_count = wc_q;
`ifdef LOADER_CHECKSUM_EN
  assign csum       = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a DEPTH=64 and a DEPTH=2 instance share one host stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, load_start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_reset, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;
  logic        s_in_ready, s_imem_we, s_cpu_reset, s_done, s_err;
  logic [31:0] s_imem_addr, s_imem_wdata;
  logic [15:0] s_word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum, s_csum;
`endif

  imem_loader #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .err(err),
`ifdef LOADER_CHECKSUM_EN
    .csum(csum),
`endif
    .word_count(word_count)
  );

  imem_loader #(.DEPTH(2)) dut_s (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last), .imem_we(s_imem_we),
    .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .cpu_reset(s_cpu_reset),
    .done(s_done), .err(s_err),
`ifdef LOADER_CHECKSUM_EN
    .csum(s_csum),
`endif
    .word_count(s_word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         q[$];
  wr_t         sq[$];
  logic [7:0]  stim[$];
  logic [31:0] exp_sum, exp_ssum;
  logic [15:0] exp_wc, exp_swc;
  logic        exp_err, exp_serr;
  wr_t         got, want, sgot, swant;

  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      got = {imem_addr, imem_wdata};
      if (q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got=%h required=no write", got);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL write got=%h required=%h", got, want);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_imem_we) begin
      checks++;
      sgot = {s_imem_addr, s_imem_wdata};
      if (sq.size() == 0) begin
        failures++;
        $display("FAIL s_write_unexpected got=%h required=no write", sgot);
      end else begin
        swant = sq.pop_front();
        if (sgot !== swant) begin
          failures++;
          $display("FAIL s_write got=%h required=%h", sgot, swant);
        end
      end
    end
  end

  task automatic build_expect();
    int n = stim.size();
    int nw = (n + 3) / 4;
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) if (4 * i + k < n) w[8*k +: 8] = stim[4*i+k];
      if (i < 64) begin
        q.push_back({32'(4 * i), w});
        exp_sum += w;
      end
      if (i < 2) begin
        sq.push_back({32'(4 * i), w});
        exp_ssum += w;
      end
    end
    exp_wc   = 16'((nw < 64) ? nw : 64);
    exp_swc  = 16'((nw < 2) ? nw : 2);
    exp_err  = nw > 64;
    exp_serr = nw > 2;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    exp_sum  = 32'h0;
    exp_ssum = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input bit rnd);
    bit sent = 0;
    int budget = 0;
    while (!sent) begin
      if (rnd && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sent     = in_ready;
      end
      @(posedge clk); #1;
      budget++;
      if (!sent && budget > 100) begin
        checks++;
        failures++;
        $display("FAIL byte_accept got=no handshake required=handshake within 100 cycles");
        sent = 1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_load(input bit rnd);
    build_expect();
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], i == stim.size() - 1, rnd);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_in_write got=%b required=0", done);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, cpu_reset, err, word_count} !== {1'b1, 1'b0, exp_err, exp_wc}) begin
      failures++;
      $display("FAIL done_state got=done %b cpu_reset %b err %b wc %0d required=1 0 %b %0d",
               done, cpu_reset, err, word_count, exp_err, exp_wc);
    end
    checks++;
    if ({s_done, s_cpu_reset, s_err, s_word_count} !== {1'b1, 1'b0, exp_serr, exp_swc}) begin
      failures++;
      $display("FAIL s_done_state got=done %b cpu_reset %b err %b wc %0d required=1 0 %b %0d",
               s_done, s_cpu_reset, s_err, s_word_count, exp_serr, exp_swc);
    end
    checks++;
    if (q.size() + sq.size() != 0) begin
      failures++;
      $display("FAIL writes_missing got=%0d/%0d pending required=0/0", q.size(), sq.size());
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (csum !== exp_sum || s_csum !== exp_ssum) begin
      failures++;
      $display("FAIL csum got=%h/%h required=%h/%h", csum, s_csum, exp_sum, exp_ssum);
    end
`endif
    q.delete();
    sq.delete();
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err, word_count} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL %s got=rdy %b we %b addr %h wd %h cr %b done %b err %b wc %0d required=0 0 0 0 1 0 0 0",
               tag, in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err, word_count);
    end
    checks++;
    if ({s_in_ready, s_imem_we, s_cpu_reset, s_done, s_err, s_word_count} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL s_%s got=rdy %b we %b cr %b done %b err %b wc %0d required=0 0 1 0 0 0",
               tag, s_in_ready, s_imem_we, s_cpu_reset, s_done, s_err, s_word_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    start_load();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(0);
  endtask

  task automatic test_partial();
    start_load();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(0);
  endtask

  task automatic test_random_valid();
    for (int r = 0; r < 3; r++) begin
      start_load();
      stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_load(1);
    end
  endtask

  task automatic test_overflow();
    start_load();
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(8'h10 + i));
    run_load(0);
  endtask

  task automatic test_restart();
    load_start = 1'b1;
    #1;
    checks++;
    if ({cpu_reset, done} !== 2'b10) begin
      failures++;
      $display("FAIL restart_same_cycle got=cr %b done %b required=1 0", cpu_reset, done);
    end
    @(posedge clk); #1;
    load_start = 1'b0;
    exp_sum  = 32'h0;
    exp_ssum = 32'h0;
    checks++;
    if ({cpu_reset, done, err, word_count, s_err, s_word_count, imem_addr} !==
        {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0}) begin
      failures++;
      $display("FAIL restart_clear got=cr %b done %b err %b wc %0d s_err %b s_wc %0d addr %h required=1 0 0 0 0 0 0",
               cpu_reset, done, err, word_count, s_err, s_word_count, imem_addr);
    end
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load(0);
  endtask

  task automatic test_async_reset();
    start_load();
    q.push_back({32'h0, 32'h0403_0201});
    sq.push_back({32'h0, 32'h0403_0201});
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 1'b0, 0);
    checks++;
    if ({in_ready, word_count, imem_addr} !== {1'b1, 16'd1, 32'h4}) begin
      failures++;
      $display("FAIL mid_load got=rdy %b wc %0d addr %h required=1 1 00000004",
               in_ready, word_count, imem_addr);
    end
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    sq.delete();
    test_basic();
  endtask

  initial begin
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = 8'h00;
    exp_sum    = 32'h0;
    exp_ssum   = 32'h0;
    test_reset();
    test_basic();
    test_partial();
    test_random_valid();
    test_overflow();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
